// File: rtl/stream_mux_n.sv
// stream_mux_n: N-input valid/ready stream mux with built-in arbitration.
// Optional packet lock via STREAM_MUX_PKT_LOCK_EN.
module stream_mux_n #(
  parameter int INPUTS = 4,
  parameter int WIDTH  = 64,
  parameter bit RR     = 1'b1,
  localparam int SELW  = $clog2(INPUTS)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [INPUTS-1:0]             in_valid,
  output logic [INPUTS-1:0]             in_ready,
  input  logic [INPUTS-1:0][WIDTH-1:0]  in_data,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [INPUTS-1:0]             in_last,
  output logic                          out_last,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [SELW-1:0]               out_sel
);

  logic            load;
  logic            found;
  logic            xfer;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] base;
  logic [SELW-1:0] idx;
  logic [SELW-1:0] gsel;
  logic [SELW-1:0] nxt;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic            locked;
  logic [SELW-1:0] lock_ch;
`endif

  assign load = !out_valid || out_ready;
  assign xfer = load && found;
  assign nxt  = (gsel == SELW'(INPUTS-1)) ? '0 : gsel + 1'b1;

  // first valid channel searching upward from base, wrapping
  always_comb begin
    found = 1'b0;
    gsel  = '0;
    idx   = '0;
    base  = RR ? ptr : '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (locked) begin
      found = in_valid[lock_ch];
      gsel  = lock_ch;
    end else begin
`else
    begin
`endif
      for (int i = 0; i < INPUTS; i++) begin
        idx = SELW'((int'(base) + i) % INPUTS);
        if (!found && in_valid[idx]) begin
          found = 1'b1;
          gsel  = idx;
        end
      end
    end
  end

  // one-hot ready, forced low while reset is held
  always_comb begin
    in_ready = '0;
    if (reset_n && xfer) in_ready[gsel] = 1'b1;
  end

  // output register, arbitration pointer and packet lock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      out_last  <= 1'b0;
      locked    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gsel];
      out_sel   <= gsel;
`ifdef STREAM_MUX_PKT_LOCK_EN
      out_last  <= in_last[gsel];
      locked    <= !in_last[gsel];
      lock_ch   <= gsel;
      if (in_last[gsel]) ptr <= nxt;
`else
      ptr       <= nxt;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/stream_mux_n.md
# stream_mux_n

Registered N-input stream multiplexer with valid/ready handshakes and built-in arbitration. It generalises the datapath 2:1 bus select into a parametrised, flow-controlled block. Channel choice comes from an internal fixed-priority or round-robin arbiter instead of an external select bit. It sits between multiple producers (e.g. functional-unit result buses) and a single consumer such as the write-back port, and provides one output pipeline register.

## Interface
- INPUTS, 4, number of input channels (≥ 2)
- WIDTH, 64, data bits per channel
- RR, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin
- SELW, $clog2(INPUTS), width of channel index (derived, not overridden)

- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  INPUTS  per-channel valid
- in_ready  output  INPUTS  per-channel ready (combinational)
- in_data  input  [INPUTS-1:0][WIDTH-1:0]  per-channel data
- in_last  input  INPUTS  per-channel end-of-packet (only with STREAM_MUX_PKT_LOCK_EN)
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accepts beat
- out_data  output  WIDTH  registered selected data
- out_sel  output  SELW  index of the channel that supplied out_data
- out_last  output  1  registered in_last of the beat (only with STREAM_MUX_PKT_LOCK_EN)

## Operation
- load = !out_valid || out_ready. The output register can take a new beat this cycle.
- grant (one-hot, combinational) is chosen among channels with in_valid=1:
  - RR=0: lowest index wins.
  - RR=1: search starts at pointer ptr and wraps modulo INPUTS.
- in_ready[k] = load && grant[k]. At most one bit of in_ready is high per cycle.
- in_ready does not depend on in_valid[k] of ungranted channels. A channel with in_valid=0 never receives in_ready=1.
- Transfer on channel k at a rising edge when in_valid[k] && in_ready[k]:
  - out_data ← in_data[k]
  - out_sel ← k
  - out_valid ← 1
- Rising edge with out_valid && out_ready and no new transfer: out_valid ← 0. out_data and out_sel hold their values.
- A consume and a new load in the same cycle keep out_valid=1 and replace the beat. This gives full throughput: 1 beat/cycle.
- ptr (RR=1 only) becomes (k+1) mod INPUTS after a transfer from channel k. Wrap: k=INPUTS-1 sets ptr to 0. ptr does not change when no transfer occurs.
- No channel valid: no grant, register unchanged apart from consume.
- Data is passed unmodified. There is no width conversion.

## Timing
- Latency: in_data is accepted at edge N and visible on out_data after edge N, i.e. 1 cycle.
- Reset values (asynchronous, immediate on reset_n=0):
  - out_valid=0, out_data=0, out_sel=0, out_last=0
  - ptr=0, lock cleared
- in_ready is 0 throughout reset.
- Reset asserted mid-transfer: the beat in the register is discarded and arbitration restarts from ptr=0.
- Backpressure: while out_valid=1 and out_ready=0, all in_ready=0. out_data, out_sel and out_last are held stable.
- Producers must hold in_valid and in_data until accepted. The block does not check this.

## Configuration
- Macro: STREAM_MUX_PKT_LOCK_EN.
- Defined:
  - in_last and out_last ports exist.
  - After a transfer from channel k with in_last[k]=0, the arbiter locks to k. Grant stays on k regardless of other valids until a beat with in_last[k]=1 is transferred, then the lock is released.
  - ptr updates only on the transfer of a last beat.
  - A locked channel with in_valid=0 produces no grant. Other channels stall.
- Undefined: no in_last/out_last ports. Every beat is arbitrated independently.

## Test plan
- Reset: hold reset_n=0 with all in_valid=1 → out_valid=0, out_data=0, out_sel=0, in_ready=0. Release, then one cycle later → out_valid=1.
- Fixed priority (RR=0): in_valid=4'b1010, data ch1=0x11, ch3=0x33, out_ready=1 → ch1 is accepted each cycle and out_sel=1 every cycle. Ch3 is starved.
- Round-robin (RR=1): all four valid continuously, out_ready=1 → out_sel sequence 0,1,2,3,0 with one beat per cycle. The wrap from 3 to 0 is checked.
- Backpressure: out_ready=0 for 3 cycles with ch2 valid (0xAB) → out_data=0xAB held and in_ready=0. On out_ready=1 the next beat loads in the same cycle as the consume.
- Packet lock (macro defined): ch0 sends 3 beats with last on beat 3 while ch1 is valid → out_sel=0,0,0,1. Ch1 in_ready stays 0 during the packet.
- Reset mid-packet (macro defined): assert reset_n=0 after beat 2 of a ch0 packet → lock cleared. After release, ch1 is granted if ch0 is idle.
